conv_engine: RTL and testbench

Parametrised streaming KxK convolution engine; successor to the fixed 3x3 unsigned pipeline.
- Adds signed coefficients, generic kernel size and two normalisation modes: divide by weight sum, or arithmetic right shift.
- Adds output clamping and valid/ready flow control with backpressure.
- Sits between the window generator (line buffers) and the output pixel writer.

---
 rtl/conv_engine.sv | 197 +++++++++++++++++++
 tb/tb_conv_engine.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_engine.sv
// Streaming KxK convolution: signed coefficients, adder-tree accumulate, divide/shift normalise, clamp, valid/ready.
// Optional saturation statistics counter is built when CONV_STATS_EN is defined.
module conv_engine #(
    parameter int K       = 3,
    parameter int PIX_W   = 8,
    parameter int COEF_W  = 8,
    parameter int SHIFT_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_wr,
    input  logic [K*K*COEF_W-1:0] cfg_coef,
    input  logic                  cfg_mode,
    input  logic [SHIFT_W-1:0]    cfg_shift,
    output logic                  idle,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [K*K*PIX_W-1:0]  in_window,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PIX_W-1:0]      out_pixel,
    output logic                  out_clamped,
    output logic [15:0]           sat_count
);
    localparam int N      = K * K;
    localparam int L      = $clog2(N);
    localparam int PROD_W = PIX_W + COEF_W + 1;
    localparam int ACC_W  = PROD_W + L;
    localparam int WSUM_W = COEF_W + L;

    function automatic int level_cnt(input int lvl);
        int c;
        c = N;
        for (int j = 0; j < lvl; j++) c = (c + 1) / 2;
        return c;
    endfunction

    // Adder-tree levels are packed back to back in one node array; level 0 holds the products.
    function automatic int level_off(input int lvl);
        int o;
        o = 0;
        for (int j = 0; j < lvl; j++) o += level_cnt(j);
        return o;
    endfunction

    localparam int TOP   = level_off(L);
    localparam int NODES = TOP + 1;

    function automatic logic [N*COEF_W-1:0] identity_coef();
        logic [N*COEF_W-1:0] c;
        c = '0;
        c[(N/2)*COEF_W +: COEF_W] = {{(COEF_W-1){1'b0}}, 1'b1};
        return c;
    endfunction

    function automatic logic signed [WSUM_W-1:0] coef_sum(input logic [N*COEF_W-1:0] c);
        logic signed [WSUM_W-1:0] s;
        s = '0;
        for (int i = 0; i < N; i++)
            s = s + $signed({{L{c[i*COEF_W+COEF_W-1]}}, c[i*COEF_W +: COEF_W]});
        return s;
    endfunction

    // Pixel is zero-extended so it is never read as negative.
    function automatic logic signed [ACC_W-1:0] mul_ext(input logic [PIX_W-1:0] pix,
                                                        input logic [COEF_W-1:0] coef);
        logic signed [PROD_W-1:0] a;
        logic signed [PROD_W-1:0] b;
        logic signed [PROD_W-1:0] p;
        a = $signed({{COEF_W{1'b0}}, 1'b0, pix});
        b = $signed({{(PIX_W+1){coef[COEF_W-1]}}, coef});
        p = a * b;
        return {{L{p[PROD_W-1]}}, p};
    endfunction

    logic [N*COEF_W-1:0]      coef_r;
    logic                     mode_r;
    logic [SHIFT_W-1:0]       shift_r;
    logic signed [WSUM_W-1:0] wsum_r;
    logic [L:0]               valid_r;
    logic signed [ACC_W-1:0]  tree_r [NODES];
    logic signed [ACC_W-1:0]  prod_s [N];
    logic signed [ACC_W-1:0]  q_s;
    logic signed [ACC_W-1:0]  wsum_ext_s;
    logic [PIX_W-1:0]         pix_s;
    logic                     clamp_s;
    logic                     out_valid_r;
    logic [PIX_W-1:0]         out_pixel_r;
    logic                     out_clamped_r;
    logic                     en_s;
    logic                     accept_s;

    assign en_s        = !out_valid_r || out_ready;
    assign in_ready    = en_s && !cfg_wr;
    assign accept_s    = in_valid && in_ready;
    assign idle        = !(|valid_r) && !out_valid_r;
    assign out_valid   = out_valid_r;
    assign out_pixel   = out_pixel_r;
    assign out_clamped = out_clamped_r;

    // Configuration registers; writes are only honoured with an empty pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coef_r  <= identity_coef();
            mode_r  <= 1'b0;
            shift_r <= '0;
            wsum_r  <= {{(WSUM_W-1){1'b0}}, 1'b1};
        end else if (cfg_wr && idle) begin
            coef_r  <= cfg_coef;
            mode_r  <= cfg_mode;
            shift_r <= cfg_shift;
            wsum_r  <= coef_sum(cfg_coef);
        end
    end

    // Per-tap products of the incoming window.
    always_comb begin
        for (int i = 0; i < N; i++)
            prod_s[i] = mul_ext(in_window[i*PIX_W +: PIX_W], coef_r[i*COEF_W +: COEF_W]);
    end

    // Product stage and adder tree; an unpaired operand is carried forward unchanged.
    always_ff @(posedge clk) begin
        if (en_s) begin
            for (int i = 0; i < N; i++) tree_r[i] <= prod_s[i];
            for (int g = 1; g <= L; g++) begin
                for (int i = 0; i < level_cnt(g); i++) begin
                    if (2 * i + 1 < level_cnt(g - 1))
                        tree_r[level_off(g) + i] <= tree_r[level_off(g - 1) + 2 * i]
                                                  + tree_r[level_off(g - 1) + 2 * i + 1];
                    else
                        tree_r[level_off(g) + i] <= tree_r[level_off(g - 1) + 2 * i];
                end
            end
        end
    end

    // Normalise the accumulated sum and clamp it into the pixel range.
    always_comb begin
        wsum_ext_s = {{(ACC_W-WSUM_W){wsum_r[WSUM_W-1]}}, wsum_r};
        q_s        = tree_r[TOP];
        pix_s      = '0;
        clamp_s    = 1'b0;
        if (mode_r) begin
            q_s = tree_r[TOP] >>> shift_r;
        end else if (!wsum_r[WSUM_W-1] && (wsum_r != '0)) begin
            q_s = tree_r[TOP] / wsum_ext_s;
        end else begin
            q_s = tree_r[TOP];
        end
        if (q_s[ACC_W-1]) begin
            pix_s   = '0;
            clamp_s = 1'b1;
        end else if (|q_s[ACC_W-2:PIX_W]) begin
            pix_s   = '1;
            clamp_s = 1'b1;
        end else begin
            pix_s   = q_s[PIX_W-1:0];
            clamp_s = 1'b0;
        end
    end

    // Stage valid bits and the output register; everything holds while downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r       <= '0;
            out_valid_r   <= 1'b0;
            out_pixel_r   <= '0;
            out_clamped_r <= 1'b0;
        end else if (en_s) begin
            valid_r     <= {valid_r[L-1:0], accept_s};
            out_valid_r <= valid_r[L];
            if (valid_r[L]) begin
                out_pixel_r   <= pix_s;
                out_clamped_r <= clamp_s;
            end
        end
    end

`ifdef CONV_STATS_EN
    logic [15:0] sat_count_r;

    // Count clamped results as they are handed downstream, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_count_r <= 16'h0000;
        end else if (out_valid_r && out_ready && out_clamped_r && (sat_count_r != 16'hFFFF)) begin
            sat_count_r <= sat_count_r + 16'h0001;
        end
    end

    assign sat_count = sat_count_r;
`else
    assign sat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_conv_engine.sv
// Self-checking bench for conv_engine: directed cases plus randomized windows/configs against an arithmetic model.
module tb_conv_engine;
    localparam int K       = 3;
    localparam int NN      = K * K;
    localparam int PIX_W   = 8;
    localparam int COEF_W  = 8;
    localparam int SHIFT_W = 5;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   cfg_wr = 1'b0;
    logic [NN*COEF_W-1:0]   cfg_coef = '0;
    logic                   cfg_mode = 1'b0;
    logic [SHIFT_W-1:0]     cfg_shift = '0;
    logic                   idle;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [NN*PIX_W-1:0]    in_window = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [PIX_W-1:0]       out_pixel;
    logic                   out_clamped;
    logic [15:0]            sat_count;

    conv_engine #(.K(K), .PIX_W(PIX_W), .COEF_W(COEF_W), .SHIFT_W(SHIFT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_coef(cfg_coef), .cfg_mode(cfg_mode),
        .cfg_shift(cfg_shift), .idle(idle), .in_valid(in_valid), .in_ready(in_ready),
        .in_window(in_window), .out_valid(out_valid), .out_ready(out_ready),
        .out_pixel(out_pixel), .out_clamped(out_clamped), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int m_coef [NN];
    int m_mode;
    int m_shift;
    int cur_win [NN];

    logic [7:0] exp_pix_q [$];
    logic       exp_cl_q  [$];
    logic [7:0] got_pix_q [$];
    logic       got_cl_q  [$];
    int         acc_cyc_q [$];
    int         got_cyc_q [$];

    logic       s_in_ready, s_out_valid, s_idle, s_cl;
    logic [7:0] s_pix;
    logic [15:0] s_sat;

    int ones [NN];
    int lap  [NN];

    // Convolution result from plain integer arithmetic on the model configuration.
    function automatic void model(input int win[NN], output int pix, output bit cl);
        int acc, ws, q;
        acc = 0;
        ws  = 0;
        for (int i = 0; i < NN; i++) begin
            acc += win[i] * m_coef[i];
            ws  += m_coef[i];
        end
        if (m_mode == 1)  q = acc >>> m_shift;
        else if (ws > 0)  q = acc / ws;
        else              q = acc;
        if (q < 0)        begin pix = 0;   cl = 1'b1; end
        else if (q > 255) begin pix = 255; cl = 1'b1; end
        else              begin pix = q;   cl = 1'b0; end
    endfunction

    task automatic clear_q();
        exp_pix_q.delete(); exp_cl_q.delete(); got_pix_q.delete(); got_cl_q.delete();
        acc_cyc_q.delete(); got_cyc_q.delete();
    endtask

    task automatic set_window(input int win[NN]);
        cur_win = win;
        for (int i = 0; i < NN; i++) in_window[i*PIX_W +: PIX_W] = win[i][7:0];
    endtask

    // One clock: sample on the falling edge, log handshakes, then advance past the rising edge.
    task automatic step();
        int p;
        bit c;
        @(negedge clk);
        s_in_ready = in_ready; s_out_valid = out_valid; s_idle = idle;
        s_pix = out_pixel; s_cl = out_clamped; s_sat = sat_count;
        if (rst_n && in_valid && in_ready) begin
            model(cur_win, p, c);
            exp_pix_q.push_back(p[7:0]); exp_cl_q.push_back(c); acc_cyc_q.push_back(cyc);
        end
        if (rst_n && out_valid && out_ready) begin
            got_pix_q.push_back(out_pixel); got_cl_q.push_back(out_clamped); got_cyc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0; in_valid = 1'b0; cfg_wr = 1'b0; out_ready = 1'b0;
        repeat (n) step();
        rst_n = 1'b1; out_ready = 1'b1;
        clear_q();
        for (int i = 0; i < NN; i++) m_coef[i] = (i == NN / 2) ? 1 : 0;
        m_mode = 0; m_shift = 0;
    endtask

    task automatic cfg_write(input int coef[NN], input int mode, input int shift, input bit honour);
        for (int i = 0; i < NN; i++) cfg_coef[i*COEF_W +: COEF_W] = coef[i][7:0];
        cfg_mode = mode[0]; cfg_shift = shift[4:0]; cfg_wr = 1'b1;
        step();
        cfg_wr = 1'b0;
        if (honour) begin m_coef = coef; m_mode = mode; m_shift = shift; end
    endtask

    task automatic wait_results(input int n);
        int budget;
        budget = 0;
        while (got_pix_q.size() < n && budget < 100) begin step(); budget++; end
    endtask

    task automatic run_one(input int win[NN]);
        int budget;
        clear_q();
        set_window(win); in_valid = 1'b1;
        budget = 0;
        while (exp_pix_q.size() == 0 && budget < 20) begin step(); budget++; end
        in_valid = 1'b0;
        wait_results(1);
    endtask

    task automatic rand_window(output int win[NN]);
        for (int i = 0; i < NN; i++) win[i] = int'($urandom_range(0, 255));
    endtask

    task automatic test_reset();
        do_reset(2);
        step();
        checks += 6;
        if (s_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", s_out_valid); end
        if (s_pix !== 8'd0)       begin errors++; $display("FAIL reset_out_pixel got=%0d exp=0", s_pix); end
        if (s_cl !== 1'b0)        begin errors++; $display("FAIL reset_out_clamped got=%b exp=0", s_cl); end
        if (s_sat !== 16'd0)      begin errors++; $display("FAIL reset_sat_count got=%0d exp=0", s_sat); end
        if (s_idle !== 1'b1)      begin errors++; $display("FAIL reset_idle got=%b exp=1", s_idle); end
        if (s_in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got=%b exp=1", s_in_ready); end
    endtask

    task automatic test_identity();
        int win [NN];
        for (int i = 0; i < NN; i++) win[i] = 255;
        win[NN/2] = 128;
        run_one(win);
        checks++;
        if (got_pix_q.size() != 1) begin
            errors++; $display("FAIL identity_count got=%0d exp=1", got_pix_q.size());
        end else begin
            checks += 3;
            if (got_pix_q[0] !== 8'h80) begin errors++; $display("FAIL identity_pixel got=%0d exp=128", got_pix_q[0]); end
            if (got_cl_q[0] !== 1'b0)   begin errors++; $display("FAIL identity_clamped got=%b exp=0", got_cl_q[0]); end
            if (got_cyc_q[0] - acc_cyc_q[0] != 6) begin
                errors++; $display("FAIL identity_latency got=%0d exp=6", got_cyc_q[0] - acc_cyc_q[0]);
            end
        end
        for (int r = 0; r < 4; r++) begin
            rand_window(win);
            run_one(win);
            checks++;
            if (got_pix_q.size() != 1 || got_pix_q[0] !== win[NN/2][7:0] || got_cl_q[0] !== 1'b0) begin
                errors++; $display("FAIL identity_random got=%0d exp=%0d", got_pix_q.size() ? got_pix_q[0] : 8'd0, win[NN/2]);
            end
        end
    endtask

    task automatic test_divide();
        int win [NN];
        int cf  [NN];
        cfg_write(ones, 0, 0, 1'b1);
        for (int i = 0; i < NN; i++) win[i] = 10 * (i + 1);
        run_one(win);
        checks++;
        if (got_pix_q.size() != 1 || got_pix_q[0] !== 8'd50 || got_cl_q[0] !== 1'b0) begin
            errors++; $display("FAIL divide_box got=%0d exp=50", got_pix_q.size() ? got_pix_q[0] : 8'd0);
        end
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NN; i++) cf[i] = int'($urandom_range(0, 255)) - 128;
            cfg_write(cf, 0, 0, 1'b1);
            rand_window(win);
            run_one(win);
            checks++;
            if (got_pix_q.size() != 1 || exp_pix_q.size() != 1 ||
                got_pix_q[0] !== exp_pix_q[0] || got_cl_q[0] !== exp_cl_q[0]) begin
                errors++; $display("FAIL divide_random got=%0d exp=%0d", got_pix_q.size() ? got_pix_q[0] : 8'd0,
                                   exp_pix_q.size() ? exp_pix_q[0] : 8'd0);
            end
        end
    endtask

    task automatic test_laplacian();
        int win [NN];
        int exp_p [3];
        bit exp_c [3];
        int exp_sat;
        exp_p = '{0, 255, 0};
        exp_c = '{1'b0, 1'b1, 1'b1};
        do_reset(1);
        cfg_write(lap, 0, 0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < NN; i++) win[i] = 100;
            win[NN/2] = (c == 0) ? 100 : (c == 1) ? 200 : 0;
            run_one(win);
            checks++;
            if (got_pix_q.size() != 1 || got_pix_q[0] !== exp_p[c][7:0] || got_cl_q[0] !== exp_c[c]) begin
                errors++; $display("FAIL laplacian_%0d got=%0d/%b exp=%0d/%b", c,
                                   got_pix_q.size() ? got_pix_q[0] : 8'd0, got_cl_q.size() ? got_cl_q[0] : 1'b0,
                                   exp_p[c], exp_c[c]);
            end
        end
        step();
`ifdef CONV_STATS_EN
        exp_sat = 2;
`else
        exp_sat = 0;
`endif
        checks++;
        if (s_sat !== exp_sat[15:0]) begin errors++; $display("FAIL sat_count got=%0d exp=%0d", s_sat, exp_sat); end
    endtask

    task automatic test_shift();
        int win [NN];
        int cf  [NN];
        int sh;
        cfg_write(ones, 1, 3, 1'b1);
        for (int i = 0; i < NN; i++) win[i] = 16;
        run_one(win);
        checks++;
        if (got_pix_q.size() != 1 || got_pix_q[0] !== 8'd18 || got_cl_q[0] !== 1'b0) begin
            errors++; $display("FAIL shift_16 got=%0d exp=18", got_pix_q.size() ? got_pix_q[0] : 8'd0);
        end
        for (int i = 0; i < NN; i++) win[i] = 255;
        run_one(win);
        checks++;
        if (got_pix_q.size() != 1 || got_pix_q[0] !== 8'd255 || got_cl_q[0] !== 1'b1) begin
            errors++; $display("FAIL shift_255 got=%0d exp=255 clamped", got_pix_q.size() ? got_pix_q[0] : 8'd0);
        end
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NN; i++) cf[i] = int'($urandom_range(0, 255)) - 128;
            sh = int'($urandom_range(0, 12));
            cfg_write(cf, 1, sh, 1'b1);
            rand_window(win);
            run_one(win);
            checks++;
            if (got_pix_q.size() != 1 || exp_pix_q.size() != 1 ||
                got_pix_q[0] !== exp_pix_q[0] || got_cl_q[0] !== exp_cl_q[0]) begin
                errors++; $display("FAIL shift_random got=%0d exp=%0d", got_pix_q.size() ? got_pix_q[0] : 8'd0,
                                   exp_pix_q.size() ? exp_pix_q[0] : 8'd0);
            end
        end
    endtask

    task automatic test_back_to_back();
        int wins [20][NN];
        logic [7:0] hold_pix;
        logic hold_cl;
        hold_pix = 8'd0;
        hold_cl  = 1'b0;
        for (int w = 0; w < 20; w++) rand_window(wins[w]);
        cfg_write(ones, 1, 3, 1'b1);
        clear_q();
        for (int t = 0; t < 80 && got_pix_q.size() < 20; t++) begin
            out_ready = !(t >= 12 && t < 17);
            if (exp_pix_q.size() < 20) begin set_window(wins[exp_pix_q.size()]); in_valid = 1'b1; end
            else in_valid = 1'b0;
            step();
            if (t >= 12 && t < 17) begin
                checks += 2;
                if (s_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready t=%0d got=%b exp=0", t, s_in_ready); end
                if (s_out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid t=%0d got=%b exp=1", t, s_out_valid); end
                if (t == 12) begin
                    hold_pix = s_pix; hold_cl = s_cl;
                end else begin
                    checks++;
                    if (s_pix !== hold_pix || s_cl !== hold_cl) begin
                        errors++; $display("FAIL stall_hold t=%0d got=%0d exp=%0d", t, s_pix, hold_pix);
                    end
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (got_pix_q.size() != 20 || exp_pix_q.size() != 20) begin
            errors++; $display("FAIL b2b_count got=%0d exp=20", got_pix_q.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (got_pix_q[i] !== exp_pix_q[i] || got_cl_q[i] !== exp_cl_q[i]) begin
                    errors++; $display("FAIL b2b_result_%0d got=%0d exp=%0d", i, got_pix_q[i], exp_pix_q[i]);
                end
            end
            checks += 3;
            if (acc_cyc_q[19] - acc_cyc_q[0] != 24) begin
                errors++; $display("FAIL b2b_accept_span got=%0d exp=24", acc_cyc_q[19] - acc_cyc_q[0]);
            end
            if (got_cyc_q[19] - got_cyc_q[0] != 24) begin
                errors++; $display("FAIL b2b_output_span got=%0d exp=24", got_cyc_q[19] - got_cyc_q[0]);
            end
            if (got_cyc_q[5] - got_cyc_q[0] != 5) begin
                errors++; $display("FAIL b2b_prestall_rate got=%0d exp=5", got_cyc_q[5] - got_cyc_q[0]);
            end
        end
    endtask

    task automatic test_control();
        int win [NN];
        int budget;
        // Write while a sample is in flight must be dropped.
        cfg_write(ones, 0, 0, 1'b1);
        clear_q();
        rand_window(win);
        set_window(win); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cfg_write(lap, 0, 0, 1'b0);
        checks += 2;
        if (s_in_ready !== 1'b0) begin errors++; $display("FAIL busy_cfg_in_ready got=%b exp=0", s_in_ready); end
        if (s_idle !== 1'b0)     begin errors++; $display("FAIL busy_cfg_idle got=%b exp=0", s_idle); end
        wait_results(1);
        for (int i = 0; i < NN; i++) win[i] = 10 * (i + 1);
        run_one(win);
        checks++;
        if (got_pix_q.size() != 1 || got_pix_q[0] !== 8'd50) begin
            errors++; $display("FAIL busy_cfg_ignored got=%0d exp=50", got_pix_q.size() ? got_pix_q[0] : 8'd0);
        end
        // Write coinciding with a valid window: window waits, then uses the new coefficients.
        clear_q();
        for (int i = 0; i < NN; i++) win[i] = 100;
        win[NN/2] = 200;
        set_window(win); in_valid = 1'b1;
        cfg_write(lap, 0, 0, 1'b1);
        checks += 2;
        if (s_in_ready !== 1'b0) begin errors++; $display("FAIL cfg_same_cycle_in_ready got=%b exp=0", s_in_ready); end
        if (exp_pix_q.size() != 0) begin errors++; $display("FAIL cfg_same_cycle_accept got=%0d exp=0", exp_pix_q.size()); end
        budget = 0;
        while (exp_pix_q.size() == 0 && budget < 20) begin step(); budget++; end
        in_valid = 1'b0;
        wait_results(1);
        checks++;
        if (got_pix_q.size() != 1 || got_pix_q[0] !== 8'd255 || got_cl_q[0] !== 1'b1) begin
            errors++; $display("FAIL cfg_same_cycle_result got=%0d exp=255", got_pix_q.size() ? got_pix_q[0] : 8'd0);
        end
        // Reset with samples in flight discards them and restores identity coefficients.
        clear_q();
        for (int w = 0; w < 3; w++) begin
            rand_window(win); set_window(win); in_valid = 1'b1; step();
        end
        in_valid = 1'b0;
        do_reset(1);
        step();
        checks += 3;
        if (s_out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got=%b exp=0", s_out_valid); end
        if (s_idle !== 1'b1)      begin errors++; $display("FAIL midreset_idle got=%b exp=1", s_idle); end
        if (s_sat !== 16'd0)      begin errors++; $display("FAIL midreset_sat_count got=%0d exp=0", s_sat); end
        repeat (10) step();
        checks++;
        if (got_pix_q.size() != 0) begin errors++; $display("FAIL midreset_leak got=%0d exp=0", got_pix_q.size()); end
        for (int i = 0; i < NN; i++) win[i] = 255;
        win[NN/2] = 128;
        run_one(win);
        checks++;
        if (got_pix_q.size() != 1 || got_pix_q[0] !== 8'h80) begin
            errors++; $display("FAIL midreset_identity got=%0d exp=128", got_pix_q.size() ? got_pix_q[0] : 8'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < NN; i++) begin
            ones[i] = 1;
            lap[i]  = (i == NN / 2) ? 8 : -1;
        end
        test_reset();
        test_identity();
        test_divide();
        test_laplacian();
        test_shift();
        test_back_to_back();
        test_control();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
